// File: rtl/fpu_fpf_pkg.sv
// Shared single-precision field layout, constants and divider states.
// The FP multiplier uses the same package.
package fpu_fpf_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    ITER = 2'd2,
    NORM = 2'd3
  } fpf_div_state_e;

endpackage

// File: rtl/fpu_fpf_div_step.sv
// One restoring-division step: subtract the divisor when it fits, emit the
// quotient bit, then shift the partial remainder left.
module fpu_fpf_div_step (
  input  logic [24:0] r,
  input  logic [23:0] mb,
  output logic [24:0] r_next,
  output logic        qbit
);

  logic [23:0] diff;
  logic [23:0] rem;

  // r stays below 2*mb, so r-mb always fits in 24 bits when it is taken
  always_comb begin
    qbit   = (r >= {1'b0, mb});
    diff   = r[23:0] - mb;
    rem    = qbit ? diff : r[23:0];
    r_next = {rem, 1'b0};
  end

endmodule

// File: rtl/fpu_fpf_div.sv
// Multi-cycle single-precision divider, dst = srca / srcb.
// Denormals flush to zero, results truncate, overflow saturates to inf.
//
// state | meaning
// IDLE  | waiting for isen; operands latched on accept
// SPEC  | special-case result pending, written on next edge
// ITER  | restoring division, BITS_PER_CYCLE quotient bits per clock
// NORM  | normalise quotient, range-check exponent, write dst
module fpu_fpf_div
  import fpu_fpf_pkg::*;
#(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] NAN_VALUE      = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isen,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic [31:0] dst,
  output logic        busy,
  output logic        done
);

  localparam int N_ITER = 25 / BITS_PER_CYCLE;

  fpf_div_state_e state;
  logic [4:0]     cnt;
  logic           sc;
  logic [7:0]     ea;
  logic [7:0]     eb;
  logic [23:0]    mb;
  logic [24:0]    r;
  logic [24:0]    q;
  logic [31:0]    spec_res;

  // operand classification on the raw inputs, used only at accept
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic in_sign;
  logic spec_hit;
  logic [31:0] spec_val;

  always_comb begin
    in_sign = srca[31] ^ srcb[31];
    a_zero  = (srca[30:23] == 8'd0);
    b_zero  = (srcb[30:23] == 8'd0);
    a_inf   = (srca[30:23] == EXP_MAX) && (srca[22:0] == 23'd0);
    b_inf   = (srcb[30:23] == EXP_MAX) && (srcb[22:0] == 23'd0);
    a_nan   = (srca[30:23] == EXP_MAX) && (srca[22:0] != 23'd0);
    b_nan   = (srcb[30:23] == EXP_MAX) && (srcb[22:0] != 23'd0);
  end

  // special-case priority: invalid, then infinite, then zero result
  always_comb begin
    spec_hit = 1'b1;
    spec_val = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = NAN_VALUE;
    end else if (a_inf || b_zero) begin
      spec_val = {in_sign, POS_INF[30:0]};
    end else if (a_zero || b_inf) begin
      spec_val = {in_sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // chain of restoring steps resolving BITS_PER_CYCLE bits, MSB first
  logic [24:0] r_ch [BITS_PER_CYCLE+1];
  logic [24:0] q_ch [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qb;

  assign r_ch[0] = r;
  assign q_ch[0] = q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    fpu_fpf_div_step u_step (
      .r      (r_ch[i]),
      .mb     (mb),
      .r_next (r_ch[i+1]),
      .qbit   (qb[i])
    );
    assign q_ch[i+1] = {q_ch[i][23:0], qb[i]};
  end

  // normalisation: q[24] set means the mantissa ratio was >= 1
  logic signed [9:0] exc;
  logic [22:0]       frac;
  logic [31:0]       norm_res;

  always_comb begin
    exc  = $signed({2'b00, ea}) - $signed({2'b00, eb})
         + 10'(BIAS - 1) + $signed({9'd0, q[24]});
    frac = q[24] ? q[23:1] : q[22:0];
    if (exc <= 10'sd0) begin
      norm_res = {sc, 31'd0};
    end else if (exc >= 10'sd255) begin
      norm_res = {sc, POS_INF[30:0]};
    end else begin
      norm_res = {sc, exc[7:0], frac};
    end
  end

  assign busy = (state != IDLE);

  // control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      sc       <= 1'b0;
      ea       <= 8'd0;
      eb       <= 8'd0;
      mb       <= 24'd0;
      r        <= 25'd0;
      q        <= 25'd0;
      spec_res <= 32'd0;
      dst      <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (isen) begin
            sc       <= in_sign;
            ea       <= srca[30:23];
            eb       <= srcb[30:23];
            mb       <= {1'b1, srcb[22:0]};
            r        <= {2'b01, srca[22:0]};
            q        <= 25'd0;
            cnt      <= 5'(N_ITER - 1);
            spec_res <= spec_val;
            state    <= spec_hit ? SPEC : ITER;
          end
        end
        SPEC: begin
          dst   <= spec_res;
          done  <= 1'b1;
          state <= IDLE;
        end
        ITER: begin
          r <= r_ch[BITS_PER_CYCLE];
          q <= q_ch[BITS_PER_CYCLE];
          if (cnt == 5'd0) begin
            state <= NORM;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        NORM: begin
          dst   <= norm_res;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_fpf_div.sv
// Directed bench for fpu_fpf_div: one instance with 1 bit/cycle and one
// with 5 bits/cycle, vector table plus handshake and reset sequences.
module tb_fpu_fpf_div;

  logic        clk;
  logic        rst_n;
  logic        isen1, isen5;
  logic [31:0] srca, srcb;
  logic [31:0] dst1, dst5;
  logic        busy1, busy5, done1, done5;

  int n_cmp;
  int n_err;

  fpu_fpf_div #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .isen(isen1), .srca(srca), .srcb(srcb),
    .dst(dst1), .busy(busy1), .done(done1)
  );

  fpu_fpf_div #(.BITS_PER_CYCLE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .isen(isen5), .srca(srca), .srcb(srcb),
    .dst(dst5), .busy(busy5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w5;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dsel(input bit w5);
    return w5 ? dst5 : dst1;
  endfunction

  function automatic logic dnsel(input bit w5);
    return w5 ? done5 : done1;
  endfunction

  function automatic logic bsel(input bit w5);
    return w5 ? busy5 : busy1;
  endfunction

  // drive operands and hold isen for one edge; returns #1 after accept edge
  task automatic accept(input bit w5, input logic [31:0] a, input logic [31:0] b);
    srca = a;
    srcb = b;
    if (w5) isen5 = 1'b1; else isen1 = 1'b1;
    @(posedge clk);
    #1;
    isen1 = 1'b0;
    isen5 = 1'b0;
  endtask

  // waits for done; lat = cycles after accept edge, 0 on timeout
  task automatic wait_done(input bit w5, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (dnsel(w5)) begin
        lat = k;
        if (bsel(w5)) busy_ok = 1'b0;
        break;
      end
      if (!bsel(w5)) busy_ok = 1'b0;
    end
  endtask

  int  lat;
  bit  bok;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    isen1 = 1'b0;
    isen5 = 1'b0;
    srca  = 32'd0;
    srcb  = 32'd0;

    vecs[0]  = '{1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 26, "6/2"};
    vecs[1]  = '{1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, "1/3"};
    vecs[2]  = '{1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 6,  "1/3 x5"};
    vecs[3]  = '{1'b0, 32'hBF800000, 32'h00000000, 32'hFF800000, 1,  "-1/0"};
    vecs[4]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 1,  "0/0"};
    vecs[5]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1,  "nan/1"};
    vecs[6]  = '{1'b0, 32'h3F800000, 32'hFF800000, 32'h80000000, 1,  "1/-inf"};
    vecs[7]  = '{1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 26, "overflow"};
    vecs[8]  = '{1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 26, "underflow"};
    vecs[9]  = '{1'b0, 32'h00400000, 32'h3F800000, 32'h00000000, 1,  "denorm/1"};
    vecs[10] = '{1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 6,  "6/2 x5"};
    vecs[11] = '{1'b0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 26, "-6/2"};

    #12;
    check("reset dst",  dst1, 32'd0);
    check("reset busy", {31'd0, busy1}, 32'd0);
    check("reset done", {31'd0, done1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      accept(vecs[i].w5, vecs[i].a, vecs[i].b);
      check({vecs[i].name, " busy@accept"}, {31'd0, bsel(vecs[i].w5)}, 32'd1);
      wait_done(vecs[i].w5, lat, bok);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, " dst"}, dsel(vecs[i].w5), vecs[i].exp);
      check({vecs[i].name, " busy"}, {31'd0, bok}, 32'd1);
      @(posedge clk);
      #1;
      check({vecs[i].name, " done drop"}, {31'd0, dnsel(vecs[i].w5)}, 32'd0);
      check({vecs[i].name, " dst hold"}, dsel(vecs[i].w5), vecs[i].exp);
    end

    // isen while busy must be ignored
    accept(1'b0, 32'h40C00000, 32'h40000000);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        srca  = 32'h3F800000;
        srcb  = 32'h40400000;
        isen1 = 1'b1;
      end
      @(posedge clk);
      #1;
      isen1 = 1'b0;
      if (done1) begin
        lat = k;
        break;
      end
    end
    check("busy-isen latency", 32'(lat), 32'd26);
    check("busy-isen dst", dst1, 32'h40400000);
    @(posedge clk);
    #1;
    check("busy-isen no restart", {31'd0, busy1}, 32'd0);

    // back-to-back: accept in the done cycle
    accept(1'b0, 32'h40C00000, 32'h40000000);
    wait_done(1'b0, lat, bok);
    check("b2b first dst", dst1, 32'h40400000);
    accept(1'b0, 32'h3F800000, 32'h40400000);
    check("b2b done drop", {31'd0, done1}, 32'd0);
    check("b2b busy", {31'd0, busy1}, 32'd1);
    wait_done(1'b0, lat, bok);
    check("b2b second latency", 32'(lat), 32'd26);
    check("b2b second dst", dst1, 32'h3EAAAAAA);

    // reset mid-ITER aborts the operation
    @(posedge clk);
    #1;
    accept(1'b0, 32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid dst",  dst1, 32'd0);
    check("rst mid busy", {31'd0, busy1}, 32'd0);
    check("rst mid done", {31'd0, done1}, 32'd0);
    bok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) rst_n = 1'b1;
      if (done1) bok = 1'b0;
    end
    check("rst no done", {31'd0, bok}, 32'd1);
    accept(1'b0, 32'h40C00000, 32'h40000000);
    wait_done(1'b0, lat, bok);
    check("post-rst latency", 32'(lat), 32'd26);
    check("post-rst dst", dst1, 32'h40400000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_fpf_div.md
Name: fpu_fpf_div

Overview:
- Multi-cycle IEEE-754 single-precision divider, dst = srca / srcb; the inverse operation to the FPU's single-cycle FP multiplier, with matching numeric conventions: denormals flush to zero, results truncate (no rounding), and overflow gives signed infinity.
- Sits beside the multiplier in the FPU execute stage and uses an isen/busy/done handshake.
- Mantissa quotient comes from iterative restoring division, BITS_PER_CYCLE quotient bits per clock.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per clock; legal values 1 or 5 (must divide 25).
- NAN_VALUE, 32'h7FC0_0000, canonical quiet NaN returned for invalid operations.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- isen  input  1  start request; accepted only when busy=0.
- srca  input  32  dividend, sampled on the accept edge.
- srcb  input  32  divisor, sampled on the accept edge.
- dst  output  32  result; holds its value until the next result is written.
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse; dst is valid in the same cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dst=0, done=0, busy=0, iteration counter=0. Reset mid-operation aborts it: no done, and dst returns to 0.
- Accept: rising edge with isen=1 and busy=0 latches sign sc=sa^sb, ea, eb and mantissas ma={1,fa}, mb={1,fb} (24 bits). isen while busy=1 is ignored.
- Operand classes: exponent 0 is zero (fraction ignored); exponent 255 with fraction 0 is inf; exponent 255 with fraction nonzero is NaN.
- Special-case priority, evaluated at accept:
  - any NaN, 0/0, or inf/inf -> NAN_VALUE.
  - a=inf or b=0 -> {sc, 31'h7F80_0000}.
  - a=0 or b=inf -> {sc, 31'h0}.
  - Special cases go to state SPEC; at the next edge dst is written, done=1, state=IDLE (done is visible 1 cycle after accept).
- Normal path, states IDLE -> ITER -> NORM -> IDLE:
  - ITER: remainder r (25 bits) starts at ma, quotient q (25 bits) at 0. Per step: if r>=mb then q bit=1 and r=r-mb; then r=r<<1. Steps run MSB first, q[24] down to q[0].
  - ITER lasts 25/BITS_PER_CYCLE cycles, counted by a down-counter that reaches 0 on the last step.
  - NORM, one cycle:
    - q[24]=1: frac=q[23:1]; else frac=q[22:0].
    - exc (10-bit signed) = ea - eb + 126 + q[24].
    - exc<=0 -> dst={sc,31'h0}; exc>=255 -> dst={sc,31'h7F80_0000}; otherwise dst={sc,exc[7:0],frac}.
  - On the NORM edge: done=1 and state=IDLE.
  - Latency from accept edge to done high: 25/BITS_PER_CYCLE + 1 cycles (26 for BITS_PER_CYCLE=1).
- Back-to-back: busy=0 in the cycle done=1, so isen in that cycle is accepted; done then drops the next cycle.
- done is high for exactly one cycle per accepted operation. No remainder or sticky bit is kept (truncation).

Decomposition:
- Package fpu_fpf_pkg holds:
  - field widths (SIGN, EXP=8, FRAC=23) and BIAS=127;
  - constants EXP_MAX=255, POS_INF=32'h7F80_0000, QNAN=32'h7FC0_0000;
  - the state enum {IDLE, SPEC, ITER, NORM}.
  The multiplier is intended to share this package.
- One sub-module, fpu_fpf_div_step: a combinational single restoring step, (r, mb) -> (r_next, qbit). It is instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- 6.0/2.0: 0x40C00000 / 0x40000000 -> dst=0x40400000; done exactly 26 cycles after accept; busy high for those 26 cycles.
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Repeat with BITS_PER_CYCLE=5 -> same value, done 6 cycles after accept.
- Specials, each with done 1 cycle after accept:
  - -1.0/0.0 (0xBF800000 / 0x00000000) -> 0xFF800000.
  - 0x00000000 / 0x00000000 -> 0x7FC00000.
  - 0x7FC00001 / 0x3F800000 -> 0x7FC00000.
  - 0x3F800000 / 0xFF800000 -> 0x80000000.
- Range limits:
  - 0x7F000000 / 0x3E800000 (exc=256) -> 0x7F800000.
  - 0x00800000 / 0x40000000 (exc=0) -> 0x00000000.
  - 0x00400000 (denormal) / 1.0 -> 0x00000000 via the zero special case.
- Handshake:
  - Assert isen with new operands while busy -> ignored; result matches the first operands.
  - isen in the done cycle -> second op accepted, second done 26 cycles later.
- Reset: drop rst_n mid-ITER (cycle 10) -> dst=0, busy=0 immediately with no done. After release, a new 6.0/2.0 completes normally.
